regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Write-back scheduler and scoreboard for the 32 x 32-bit MIPS `register_file`. It arbitrates the single register-file write port between the ALU and memory (load) write-back sources. It registers the winning write onto the port and tracks which destination registers have writes pending. It stalls decode on RAW and WAW hazards. It sits between the execute/memory stages and the `register_file` write inputs (`write_enable`, `rd`, `data_in`).

## Interface
- `DATA_W`, 32, write-back data width
- `ADDR_W`, 5, register index width
- `NUM_REGS`, 32, number of architectural registers (2**`ADDR_W`)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `iss_valid`  in  1  decode has an instruction that writes `iss_rd`
- `iss_rd`  in  `ADDR_W`  destination register of the decoding instruction
- `iss_rs`, `iss_rt`  in  `ADDR_W`  source registers of the decoding instruction
- `iss_stall`  out  1  combinational; issue is blocked this cycle
- `alu_valid`  in  1  ALU write-back request
- `alu_rd`  in  `ADDR_W`  ALU destination register
- `alu_data`  in  `DATA_W`  ALU result
- `alu_ready`  out  1  ALU transfer accepted this cycle
- `mem_valid`, `mem_rd`, `mem_data`, `mem_ready`  same roles for the load result
- `rf_write_enable`  out  1  registered; drives `register_file.write_enable`
- `rf_rd`  out  `ADDR_W`  registered; drives `register_file.rd`
- `rf_data_in`  out  `DATA_W`  registered; drives `register_file.data_in`
- `busy_mask`  out  `NUM_REGS`  bit i set while a write to register i is pending
- `err`  out  1  sticky; write-back to a register that was not busy

## Operation
- Scoreboard: `busy_q[NUM_REGS-1:0]`. Bit 0 is hard-wired to 0.
- `iss_stall` = `iss_valid` & (`busy_q[iss_rs]` | `busy_q[iss_rt]` | `busy_q[iss_rd]`).
  - `iss_rs`/`iss_rt` = 0 never stall.
  - `iss_rd` = 0 never stalls.
- Issue is accepted when `iss_valid` & !`iss_stall`. At that edge `busy_q[iss_rd]` is set, unless `iss_rd` = 0.
- Arbiter: one grant per cycle with a round-robin pointer `prio`. `prio` values are MEM or ALU.
  - Only one source valid: that source is granted.
  - Both valid: the `prio` source is granted, and `prio` flips to the other source.
  - `prio` changes only on a contended grant.
- `alu_ready`/`mem_ready` are combinational grants and depend only on the valids and `prio`.
- A transfer is valid & ready. A source holds `rd`/`data` stable until its transfer.
- Commit stage: a transfer in cycle N loads `rf_rd`/`rf_data_in` at the end of N.
  - `rf_write_enable` = 1 during N+1 if the transferred `rd` != 0.
  - Transfers with `rd` = 0 are accepted but produce `rf_write_enable` = 0 and set no error.
- Busy clear: at the edge ending a cycle with `rf_write_enable` = 1, `busy_q[rf_rd]` clears. This is the same edge at which `register_file` writes.
- Error: a transfer with `rd` != 0 and `busy_q[rd]` = 0 sets `err` at the end of that cycle. The write is still committed.
- Simultaneous set and clear of the same register on one edge: set wins.
- With no transfer in a cycle, `rf_write_enable` = 0 the next cycle. `rf_rd`/`rf_data_in` hold their last values.

## Timing
- Reset values while `rst_n` = 0, asynchronous:
  - `busy_q` = 0, `busy_mask` = 0
  - `rf_write_enable` = 0, `rf_rd` = 0, `rf_data_in` = 0
  - `err` = 0
  - `prio` = MEM
- Reset mid-operation: a pending commit is dropped and all busy bits clear. Upstream must be flushed by the same reset.
- Latency from transfer to register-file write edge: 1 cycle.
  - Write data is readable via `rs`/`rt` from cycle N+2.
  - `iss_stall` for that register drops in cycle N+2.
- No forwarding: a dependent instruction stalls through cycles N and N+1.
- Throughput: one write-back per cycle. Under continuous dual requests, grants alternate MEM, ALU, MEM, ...
- `busy_mask` = `busy_q` (registered). The stall, grant and ready paths are purely combinational from registered state and inputs.

## Test plan
- Issue `iss_rd`=5 → `busy_mask`=0x20. Then issue with `iss_rs`=5 → `iss_stall`=1. Then ALU transfer `alu_rd`=5, data 0x12345678 in cycle N → cycle N+1 shows `rf_write_enable`=1, `rf_rd`=5, `rf_data_in`=0x12345678. In cycle N+2, `busy_mask`=0 and `iss_stall`=0.
- After reset, `alu_valid`=`mem_valid`=1 held for 4 cycles with busy rd 3 and 4 → grants MEM, ALU, MEM, ALU, and `rf_write_enable` high for 4 consecutive cycles.
- Issue `iss_rd`=0 → `busy_mask` unchanged. MEM transfer with `mem_rd`=0 → `mem_ready`=1, `rf_write_enable` stays 0, `err`=0.
- With register 7 busy, `iss_valid`=1, `iss_rd`=7, `iss_rs`=`iss_rt`=0 → `iss_stall`=1 until the commit edge for register 7.
- MEM transfer `mem_rd`=9 while register 9 is not busy → `err`=1 the next cycle and stays 1. The write still occurs: `rf_rd`=9, `rf_write_enable`=1.
- Drive `rst_n`=0 mid-cycle while `rf_write_enable`=1 and `busy_mask`=0x80 → all outputs 0 immediately, with no clock edge needed. After release, the first contended grant goes to MEM.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back scheduler bus bundle.
// Carries the decode issue port, the ALU and load write-back request ports,
// and the register-file write port. It also carries the scoreboard and error status.
interface regfile_wb_scheduler_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
);
    // Decode issue port
    logic                iss_valid;
    logic [ADDR_W-1:0]   iss_rd;
    logic [ADDR_W-1:0]   iss_rs;
    logic [ADDR_W-1:0]   iss_rt;
    logic                iss_stall;

    // ALU write-back source
    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;

    // Load write-back source
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_rd;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;

    // Register-file write port and status
    logic                rf_write_enable;
    logic [ADDR_W-1:0]   rf_rd;
    logic [DATA_W-1:0]   rf_data_in;
    logic [NUM_REGS-1:0] busy_mask;
    logic                err;

    // Upstream side: decode, execute/memory stages and register file
    modport master (
        output iss_valid, iss_rd, iss_rs, iss_rt,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  iss_stall, alu_ready, mem_ready,
        input  rf_write_enable, rf_rd, rf_data_in, busy_mask, err
    );

    // Scheduler side
    modport slave (
        input  iss_valid, iss_rd, iss_rs, iss_rt,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output iss_stall, alu_ready, mem_ready,
        output rf_write_enable, rf_rd, rf_data_in, busy_mask, err
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and scoreboard for the 32 x 32-bit MIPS register file.
// The ALU and load results share the single write port. Arbitration is
// round-robin on contention. The winning write is registered onto the port
// for one cycle. A per-register busy scoreboard stalls decode on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_scheduler_if.slave  bus
);

    typedef enum logic {
        PRIO_MEM = 1'b0,
        PRIO_ALU = 1'b1
    } prio_e;

    prio_e               prio_q, prio_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;
    logic                err_q, err_d;

    logic                grant_alu;
    logic                grant_mem;
    logic                xfer;
    logic [ADDR_W-1:0]   xfer_rd;
    logic [DATA_W-1:0]   xfer_data;
    logic                stall;
    logic                issue_acc;

    // Hazard check and issue acceptance. Busy bit 0 is always clear, so r0 never stalls.
    always_comb begin
        stall     = bus.iss_valid &
                    (busy_q[bus.iss_rs] | busy_q[bus.iss_rt] | busy_q[bus.iss_rd]);
        issue_acc = bus.iss_valid & ~stall;
    end

    // Round-robin grant. A lone requester always wins, and the pointer only moves on contention.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        prio_d    = prio_q;
        if (bus.alu_valid && bus.mem_valid) begin
            if (prio_q == PRIO_MEM) begin
                grant_mem = 1'b1;
                prio_d    = PRIO_ALU;
            end else begin
                grant_alu = 1'b1;
                prio_d    = PRIO_MEM;
            end
        end else begin
            grant_alu = bus.alu_valid;
            grant_mem = bus.mem_valid;
        end
    end

    // Select the transferring source's destination and data.
    always_comb begin
        xfer      = grant_alu | grant_mem;
        xfer_rd   = '0;
        xfer_data = '0;
        if (grant_mem) begin
            xfer_rd   = bus.mem_rd;
            xfer_data = bus.mem_data;
        end else if (grant_alu) begin
            xfer_rd   = bus.alu_rd;
            xfer_data = bus.alu_data;
        end
    end

    // Next commit-stage contents. Address and data hold when idle, and r0 writes are suppressed.
    always_comb begin
        rf_we_d   = xfer && (xfer_rd != '0);
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (xfer) begin
            rf_rd_d   = xfer_rd;
            rf_data_d = xfer_data;
        end
        err_d = err_q | (xfer && (xfer_rd != '0) && !busy_q[xfer_rd]);
    end

    // Scoreboard update. The clear is applied first so that a same-edge issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (issue_acc && (bus.iss_rd != '0)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers. Reset drops any pending commit and clears the scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= PRIO_MEM;
            busy_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            busy_q    <= busy_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.iss_stall       = stall;
    assign bus.alu_ready       = grant_alu;
    assign bus.mem_ready       = grant_mem;
    assign bus.rf_write_enable = rf_we_q;
    assign bus.rf_rd           = rf_rd_q;
    assign bus.rf_data_in      = rf_data_q;
    assign bus.busy_mask       = busy_q;
    assign bus.err             = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed scenarios followed by
// randomized traffic compared against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) bus ();

    regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit          m_busy [32];
    bit          m_mem_first;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.iss_rs = '0; bus.iss_rt = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_mem_first = 1'b1;
        m_we = 1'b0; m_rd = '0; m_data = '0; m_err = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.iss_valid = 1'b1; bus.iss_rd = rd; bus.iss_rs = '0; bus.iss_rt = '0;
        tick();
        bus.iss_valid = 1'b0;
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    function automatic logic [4:0] pick_rd();
        logic [4:0] r;
        for (int t = 0; t < 8; t++) begin
            r = 5'($urandom_range(1, 31));
            if (m_busy[r]) return r;
        end
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++; if (bus.busy_mask !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=%h", bus.busy_mask, 32'h0); end
        checks++; if (bus.rf_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.rf_write_enable); end
        checks++; if (bus.rf_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", bus.rf_rd); end
        checks++; if (bus.rf_data_in !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.rf_data_in); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        do_reset();
        bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin failures++; $display("FAIL reset_prio got=mem%b/alu%b exp=mem1/alu0", bus.mem_ready, bus.alu_ready); end
        idle_inputs();
    endtask

    task automatic test_issue_commit();
        do_reset();
        issue(5'd5);
        checks++; if (bus.busy_mask !== 32'h20) begin failures++; $display("FAIL issue_busy got=%h exp=%h", bus.busy_mask, 32'h20); end
        bus.iss_valid = 1'b1; bus.iss_rs = 5'd5; bus.iss_rt = 5'd0; bus.iss_rd = 5'd6;
        #1;
        checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b exp=1", bus.iss_stall); end
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h12345678;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%b exp=1", bus.alu_ready); end
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_data_in !== 32'h12345678) begin
            failures++; $display("FAIL commit_n1 got=we%b rd%0d %h exp=we1 rd5 12345678", bus.rf_write_enable, bus.rf_rd, bus.rf_data_in); end
        bus.iss_valid = 1'b1;
        #1;
        checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL stall_n1 got=%b exp=1", bus.iss_stall); end
        tick();
        checks++; if (bus.busy_mask !== 32'h0) begin failures++; $display("FAIL busy_n2 got=%h exp=0", bus.busy_mask); end
        checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL stall_n2 got=%b exp=0", bus.iss_stall); end
        checks++; if (bus.rf_write_enable !== 1'b0) begin failures++; $display("FAIL we_n2 got=%b exp=0", bus.rf_write_enable); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [4:0] prev_rd;
        bit         exp_mem;
        do_reset();
        issue(5'd3); issue(5'd4); issue(5'd5); issue(5'd6); issue(5'd7);
        checks++; if (bus.busy_mask !== 32'hF8) begin failures++; $display("FAIL b2b_busy got=%h exp=%h", bus.busy_mask, 32'hF8); end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h03030303;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h04040404;
        prev_rd = '0;
        for (int i = 0; i < 4; i++) begin
            exp_mem = (i % 2 == 0);
            #1;
            checks++; if (bus.mem_ready !== exp_mem || bus.alu_ready !== !exp_mem) begin
                failures++; $display("FAIL b2b_grant%0d got=mem%b/alu%b exp_mem=%b", i, bus.mem_ready, bus.alu_ready, exp_mem); end
            if (i > 0) begin
                checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd !== prev_rd) begin
                    failures++; $display("FAIL b2b_commit%0d got=we%b rd%0d exp=we1 rd%0d", i, bus.rf_write_enable, bus.rf_rd, prev_rd); end
            end
            prev_rd = exp_mem ? bus.mem_rd : bus.alu_rd;
            tick();
            case (i)
                0: begin bus.mem_rd = 5'd5; bus.mem_data = 32'h05050505; end
                1: begin bus.alu_rd = 5'd6; bus.alu_data = 32'h06060606; end
                2: begin bus.mem_rd = 5'd7; bus.mem_data = 32'h07070707; end
                default: ;
            endcase
        end
        idle_inputs();
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd !== 5'd6 || bus.rf_data_in !== 32'h06060606) begin
            failures++; $display("FAIL b2b_last got=we%b rd%0d %h exp=we1 rd6 06060606", bus.rf_write_enable, bus.rf_rd, bus.rf_data_in); end
        checks++; if (bus.busy_mask !== 32'hC0) begin failures++; $display("FAIL b2b_busy_end got=%h exp=%h", bus.busy_mask, 32'hC0); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        issue(5'd0);
        checks++; if (bus.busy_mask !== 32'h0) begin failures++; $display("FAIL zero_busy got=%h exp=0", bus.busy_mask); end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hDEADBEEF;
        #1;
        checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%b exp=1", bus.mem_ready); end
        tick();
        bus.mem_valid = 1'b0;
        checks++; if (bus.rf_write_enable !== 1'b0) begin failures++; $display("FAIL zero_we got=%b exp=0", bus.rf_write_enable); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL zero_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_waw_stall();
        do_reset();
        issue(5'd7);
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.iss_rs = '0; bus.iss_rt = '0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        #1;
        checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL waw_stall_n got=%b exp=1", bus.iss_stall); end
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL waw_stall_n1 got=%b exp=1", bus.iss_stall); end
        tick();
        checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL waw_stall_n2 got=%b exp=0", bus.iss_stall); end
        tick();
        bus.iss_valid = 1'b0;
        checks++; if (bus.busy_mask !== 32'h80) begin failures++; $display("FAIL waw_reissue got=%h exp=%h", bus.busy_mask, 32'h80); end
    endtask

    task automatic test_err();
        do_reset();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        tick();
        bus.mem_valid = 1'b0;
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", bus.err); end
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd !== 5'd9) begin
            failures++; $display("FAIL err_write got=we%b rd%0d exp=we1 rd9", bus.rf_write_enable, bus.rf_rd); end
        tick(); tick();
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        issue(5'd7);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hA5A5A5A5;
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.busy_mask !== 32'h80) begin
            failures++; $display("FAIL areset_pre got=we%b busy%h exp=we1 busy80", bus.rf_write_enable, bus.busy_mask); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rf_write_enable !== 1'b0 || bus.busy_mask !== 32'h0 || bus.rf_rd !== 5'd0 ||
                      bus.rf_data_in !== 32'h0 || bus.err !== 1'b0) begin
            failures++; $display("FAIL areset_now got=we%b busy%h rd%0d data%h err%b exp=all0",
                                 bus.rf_write_enable, bus.busy_mask, bus.rf_rd, bus.rf_data_in, bus.err); end
        tick();
        rst_n = 1'b1;
        bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            failures++; $display("FAIL areset_prio got=mem%b/alu%b exp=mem1/alu0", bus.mem_ready, bus.alu_ready); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit          a_hold, m_hold, e_stall, e_ga, e_gm;
        logic [4:0]  g_rd;
        logic [31:0] g_data;
        do_reset();
        a_hold = 1'b0; m_hold = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!a_hold) begin
                bus.alu_valid = ($urandom_range(0, 99) < 60);
                bus.alu_rd    = pick_rd();
                bus.alu_data  = $urandom;
                a_hold        = bus.alu_valid;
            end
            if (!m_hold) begin
                bus.mem_valid = ($urandom_range(0, 99) < 60);
                bus.mem_rd    = pick_rd();
                bus.mem_data  = $urandom;
                m_hold        = bus.mem_valid;
            end
            bus.iss_valid = ($urandom_range(0, 1) == 1);
            bus.iss_rd    = 5'($urandom_range(0, 31));
            bus.iss_rs    = 5'($urandom_range(0, 31));
            bus.iss_rt    = 5'($urandom_range(0, 31));
            #1;
            // Expected behaviour from the scheduling rules
            e_stall = bus.iss_valid && ((bus.iss_rs != 0 && m_busy[bus.iss_rs]) ||
                                        (bus.iss_rt != 0 && m_busy[bus.iss_rt]) ||
                                        (bus.iss_rd != 0 && m_busy[bus.iss_rd]));
            e_ga = 1'b0; e_gm = 1'b0;
            if (bus.alu_valid && bus.mem_valid) begin
                if (m_mem_first) e_gm = 1'b1; else e_ga = 1'b1;
                m_mem_first = !m_mem_first;
            end else if (bus.alu_valid) e_ga = 1'b1;
            else if (bus.mem_valid) e_gm = 1'b1;

            checks++; if (bus.iss_stall !== e_stall) begin failures++; $display("FAIL rnd_stall c%0d got=%b exp=%b", cyc, bus.iss_stall, e_stall); end
            checks++; if (bus.alu_ready !== e_ga || bus.mem_ready !== e_gm) begin
                failures++; $display("FAIL rnd_grant c%0d got=alu%b/mem%b exp=alu%b/mem%b", cyc, bus.alu_ready, bus.mem_ready, e_ga, e_gm); end
            checks++; if (bus.rf_write_enable !== m_we || bus.rf_rd !== m_rd || bus.rf_data_in !== m_data) begin
                failures++; $display("FAIL rnd_port c%0d got=we%b rd%0d %h exp=we%b rd%0d %h", cyc,
                                     bus.rf_write_enable, bus.rf_rd, bus.rf_data_in, m_we, m_rd, m_data); end
            checks++; if (bus.busy_mask !== model_mask()) begin failures++; $display("FAIL rnd_busy c%0d got=%h exp=%h", cyc, bus.busy_mask, model_mask()); end
            checks++; if (bus.err !== m_err) begin failures++; $display("FAIL rnd_err c%0d got=%b exp=%b", cyc, bus.err, m_err); end

            // Advance the model across the coming edge
            g_rd   = e_gm ? bus.mem_rd   : bus.alu_rd;
            g_data = e_gm ? bus.mem_data : bus.alu_data;
            if ((e_ga || e_gm) && g_rd != 0 && !m_busy[g_rd]) m_err = 1'b1;
            if (m_we) m_busy[m_rd] = 1'b0;
            if (bus.iss_valid && !e_stall && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
            if (e_ga || e_gm) begin
                m_rd = g_rd; m_data = g_data; m_we = (g_rd != 0);
            end else begin
                m_we = 1'b0;
            end
            if (e_ga) a_hold = 1'b0;
            if (e_gm) m_hold = 1'b0;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_issue_commit();
        test_back_to_back();
        test_zero_reg();
        test_waw_stall();
        test_err();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
